// File: rtl/rt_stream_pkg.sv
// Shared definitions for the render-core fragment stream: handshake widths,
// fragment size and the collector state encoding.
package rt_stream_pkg;

   localparam int FRAG_DATA_W        = 32;
   localparam int FRAG_ADDR_W        = 32;
   localparam int FRAG_DIM_W         = 16;
   localparam int BYTES_PER_FRAGMENT = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } collector_state_t;

endpackage

// File: rtl/rt_stream_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is dropped
// unless a pop frees the slot in the same cycle.
module rt_stream_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign push_ok_s = push && (!full || pop);
   assign pop_ok_s  = pop && !empty;

   // Storage array; no reset needed since contents are qualified by count_r.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fragment_collector.sv
// Collects a frame of fragments into a FIFO and writes them out as linear
// bursts at a latched framebuffer base, flagging frame-length mismatches.
module fragment_collector
   import rt_stream_pkg::*;
#(
   parameter int DATA_W     = FRAG_DATA_W,
   parameter int ADDR_W     = FRAG_ADDR_W,
   parameter int DIM_W      = FRAG_DIM_W,
   parameter int FIFO_DEPTH = 16,
   parameter int BURST_LEN  = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DIM_W-1:0]  image_width,
   input  logic [DIM_W-1:0]  image_height,
   input  logic              frag_valid,
   input  logic              frag_last,
   input  logic [DATA_W-1:0] frag_data,
   output logic              frag_ready,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              wr_last,
   input  logic              wr_ready,
   output logic              busy,
   output logic              done,
   output logic              err_early_last,
   output logic              err_missing_last
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BL_W  = $clog2(BURST_LEN) + 1;
   localparam int PIX_W = 2 * DIM_W;

   collector_state_t  state_r;
   logic [ADDR_W-1:0] base_r;
   logic [ADDR_W-1:0] tx_count_r;
   logic [PIX_W-1:0]  expected_r;
   logic [PIX_W-1:0]  rx_count_r;
   logic [BL_W-1:0]   beats_left_r;
   logic              wr_valid_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              wr_last_r;
   logic              busy_r;
   logic              done_r;
   logic              err_early_r;
   logic              err_missing_r;

   logic              push_s;
   logic              pop_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic [DATA_W-1:0] fifo_head_s;
   logic [PIX_W-1:0]  rx_next_s;
   logic              size_hit_s;
   logic              burst_go_s;
   logic [BL_W-1:0]   burst_len_s;
   logic              frame_start_s;

   assign frag_ready       = (state_r == ST_RUN) && !fifo_full_s;
   assign push_s           = frag_valid && frag_ready;
   assign pop_s            = (beats_left_r != {BL_W{1'b0}}) && (!wr_valid_r || wr_ready);
   assign frame_start_s    = (state_r == ST_IDLE) && start;
   assign rx_next_s        = rx_count_r + PIX_W'(1);
   // A zero-sized frame ends on its first fragment.
   assign size_hit_s       = (expected_r == {PIX_W{1'b0}}) || (rx_next_s == expected_r);

   assign wr_valid         = wr_valid_r;
   assign wr_addr          = wr_addr_r;
   assign wr_data          = wr_data_r;
   assign wr_last          = wr_last_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign err_early_last   = err_early_r;
   assign err_missing_last = err_missing_r;

   rt_stream_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push_s),
      .push_data (frag_data),
      .pop       (pop_s),
      .pop_data  (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Burst admission: full bursts while collecting, partial ones while flushing.
   always_comb begin
      burst_go_s  = 1'b0;
      burst_len_s = BL_W'(BURST_LEN);
      if (beats_left_r == {BL_W{1'b0}}) begin
         if ((state_r == ST_RUN) && (fifo_count_s >= CNT_W'(BURST_LEN))) begin
            burst_go_s  = 1'b1;
            burst_len_s = BL_W'(BURST_LEN);
         end else if ((state_r == ST_FLUSH) && !fifo_empty_s) begin
            burst_go_s  = 1'b1;
            burst_len_s = (fifo_count_s >= CNT_W'(BURST_LEN)) ? BL_W'(BURST_LEN)
                                                              : BL_W'(fifo_count_s);
         end else begin
            burst_go_s  = 1'b0;
         end
      end else begin
         burst_go_s = 1'b0;
      end
   end

   // Frame control FSM with registered status outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= ST_IDLE;
         base_r        <= {ADDR_W{1'b0}};
         expected_r    <= {PIX_W{1'b0}};
         rx_count_r    <= {PIX_W{1'b0}};
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         err_early_r   <= 1'b0;
         err_missing_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r       <= ST_RUN;
                  busy_r        <= 1'b1;
                  base_r        <= base_addr;
                  expected_r    <= PIX_W'(image_width) * PIX_W'(image_height);
                  rx_count_r    <= {PIX_W{1'b0}};
                  err_early_r   <= 1'b0;
                  err_missing_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (push_s) begin
                  rx_count_r <= rx_next_s;
                  if (frag_last || size_hit_s) begin
                     state_r <= ST_FLUSH;
                  end
                  if (frag_last && (rx_next_s < expected_r)) begin
                     err_early_r <= 1'b1;
                  end
                  if (size_hit_s && !frag_last) begin
                     err_missing_r <= 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               // Finish as the last outstanding beat is taken, so done follows it directly.
               if (fifo_empty_s && (beats_left_r == {BL_W{1'b0}}) && (!wr_valid_r || wr_ready)) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Write beat register: loads the FIFO head and holds it while stalled.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         beats_left_r <= {BL_W{1'b0}};
         tx_count_r   <= {ADDR_W{1'b0}};
         wr_valid_r   <= 1'b0;
         wr_addr_r    <= {ADDR_W{1'b0}};
         wr_data_r    <= {DATA_W{1'b0}};
         wr_last_r    <= 1'b0;
      end else if (frame_start_s) begin
         beats_left_r <= {BL_W{1'b0}};
         tx_count_r   <= {ADDR_W{1'b0}};
         wr_valid_r   <= 1'b0;
         wr_last_r    <= 1'b0;
      end else begin
         if (burst_go_s) begin
            beats_left_r <= burst_len_s;
         end else if (pop_s) begin
            beats_left_r <= beats_left_r - BL_W'(1);
         end
         if (pop_s) begin
            wr_valid_r <= 1'b1;
            wr_data_r  <= fifo_head_s;
            wr_addr_r  <= base_r + tx_count_r * ADDR_W'(BYTES_PER_FRAGMENT);
            wr_last_r  <= (beats_left_r == BL_W'(1));
            tx_count_r <= tx_count_r + ADDR_W'(1);
         end else if (wr_ready) begin
            wr_valid_r <= 1'b0;
            wr_last_r  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fragment_collector.md
# fragment_collector

Receiving end of the render core's fragment stream. It accepts 32-bit fragments over a valid/ready/last handshake and buffers them in a small FIFO. It then writes them to memory as linear, address-incrementing write bursts into a framebuffer at a configured base address. It sits between the render core and the memory/DMA write port, checks that the frame length agrees with the configured image size, and signals frame completion.

## Interface
- DATA_W, 32, fragment and write data width
- ADDR_W, 32, byte address width
- DIM_W, 16, width of image_width/image_height (integer pixels)
- FIFO_DEPTH, 16, fragment buffer entries; power of two, ≥ BURST_LEN
- BURST_LEN, 8, maximum beats per write burst; power of two
- clk  in  1  clock; the only clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin frame capture; sampled only in IDLE
- base_addr  in  ADDR_W  framebuffer byte address; latched on start
- image_width, image_height  in  DIM_W each  frame size in pixels; latched on start
- frag_valid  in  1  fragment present
- frag_last  in  1  final fragment of frame
- frag_data  in  DATA_W  fragment payload
- frag_ready  out  1  collector accepts fragment this cycle
- wr_valid  out  1  write beat present
- wr_addr  out  ADDR_W  byte address of the beat
- wr_data  out  DATA_W  beat payload
- wr_last  out  1  final beat of the current burst
- wr_ready  in  1  memory side accepts beat
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the frame is fully written
- err_early_last  out  1  sticky; frag_last seen before W*H fragments
- err_missing_last  out  1  sticky; W*H-th fragment arrived without frag_last

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - frag_ready=0.
  - On start: latch base_addr, expected=W*H (2*DIM_W bits), clear the counters and both err flags, then go to RUN.
  - start outside IDLE is ignored.
- RUN:
  - Fragment accepted when frag_valid && frag_ready; it is pushed to the FIFO and rx_count increments.
  - On the accepted fragment where frag_last=1 or rx_count+1==expected, go to FLUSH. No further fragments are accepted.
  - If frag_last=1 and rx_count+1<expected, set err_early_last.
  - If rx_count+1==expected and frag_last=0, set err_missing_last.
- Burst issue:
  - In RUN, a burst starts only when FIFO occupancy ≥ BURST_LEN. Its length is BURST_LEN.
  - In FLUSH, a burst starts when the FIFO is non-empty. Its length is min(occupancy, BURST_LEN).
  - Length is fixed at burst start.
  - Beats are issued back-to-back from the FIFO. wr_last is on the final beat.
- Addressing: wr_addr = base + 4*tx_count, where tx_count is the number of beats written. Wraps modulo 2^ADDR_W.
- FLUSH → DONE when the FIFO is empty and no burst is outstanding.
- DONE: done=1 for one cycle, then go to IDLE. err flags hold until the next start.
- Degenerate size: if W*H==0, the block goes RUN → FLUSH on the first accepted fragment, with err_missing_last set unless frag_last=1.

## Timing
- Reset value of every output is 0. The FIFO is emptied, the state is IDLE, and the counters are cleared.
- Reset asserted mid-frame aborts immediately. No done pulse is generated.
- frag_ready = (state==RUN) && !fifo_full. It depends only on registers, never on frag_valid or wr_ready.
- No same-cycle passthrough: a full FIFO deasserts frag_ready even if a pop occurs that cycle.
- Latency: a fragment accepted in cycle N can appear on wr_data no earlier than cycle N+1.
- wr_valid, wr_addr, wr_data and wr_last hold stable while wr_valid && !wr_ready.
- Simultaneous push and pop: occupancy is unchanged. This is legal at any occupancy except full-with-no-pop.
- done asserts in the cycle after the final burst's wr_last beat is accepted.

## Structure
- Shared package rt_stream_pkg holds:
  - collector_state_t enum
  - BYTES_PER_FRAGMENT=4
  - the fragment handshake width constants, which the render core also uses
- Sub-module rt_stream_fifo: synchronous FIFO with push/pop, full, empty and count ports, parameterised on width and depth. It is reusable by later stream stages.

## Test plan
- 2x2 frame, base 0x1000, wr_ready=1, 4 fragments with last on the 4th:
  - one 4-beat burst at 0x1000/1004/1008/100C, with wr_last on 0x100C;
  - done pulses once;
  - no err flags set.
- 4x4 frame, wr_ready=0 until 16 fragments are sent:
  - frag_ready drops after 16 accepts;
  - after wr_ready=1, two 8-beat bursts follow, with the data order preserved.
- 2x2 frame, frag_last on the 3rd fragment:
  - err_early_last=1;
  - one 3-beat burst, then done;
  - a 4th fragment offered afterwards sees frag_ready=0.
- 2x2 frame, no frag_last:
  - err_missing_last=1 after the 4th fragment;
  - 4 beats written, then done.
- Random wr_ready stalls (50%) on a 3x5 frame:
  - write payloads stay stable during stalls;
  - bursts of 8 then 7 beats;
  - addresses are contiguous.
- resetn pulsed mid-frame:
  - all outputs are 0 and the state is IDLE;
  - a new start with base 0x2000 writes its first beat to 0x2000;
  - start pulsed during RUN is ignored.
